si5340_config_sequencer: RTL and testbench
==========================================

Name: si5340_config_sequencer

Overview:
- Parametrised successor to the single-entry SI5340 config loader.
- On one start pulse it walks an entire register table, entry by entry, and issues the I2C transactions through the existing byte-level I2C controller (start/stop/read/write/cmd_ack interface).
- Adds configurable register-address width, slave-NACK retry, optional read-back verify, programmable inter-entry pause, and completion/error status.
- Sits between the board-bring-up control logic and the byte controller. The register table comes from an external synchronous ROM.

Parameters:
- SLAVE_ADDR, 7'h74, 7-bit I2C device address.
- ADDR_BYTES, 2, register-address bytes per entry (1..4), sent MSB first.
- NUM_ENTRIES, 16, table depth (>=1).
- IDX_W, $clog2(NUM_ENTRIES) (min 1), table index width.
- MEM_W, 8*(ADDR_BYTES+1), entry width: [MEM_W-1:8] register address, [7:0] data.
- PAUSE_CYCLES, 1000, idle clk cycles after each completed entry (0 = no pause).
- MAX_RETRY, 3, retries per entry after the first attempt fails.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  pulse: begin table walk; ignored while busy_o=1
- verify_i  in  1  sampled with start_i; 1 = read back and compare each entry
- rom_addr_o  out  IDX_W  table index
- rom_data_i  in  MEM_W  entry data, valid 1 cycle after rom_addr_o changes
- i2c_start_o / i2c_stop_o / i2c_read_o / i2c_write_o  out  1  byte-controller command bits
- i2c_ack_in_o  out  1  ack bit to drive on reads (1 = NACK)
- i2c_din_o  out  8  byte to transmit
- i2c_cmd_ack_i  in  1  byte-controller command complete
- i2c_ack_out_i  in  1  slave ack on writes (0 = ACK, 1 = NACK)
- i2c_dout_i  in  8  received byte
- busy_o  out  1  table walk in progress
- done_o  out  1  1-cycle pulse: walk finished (success or error)
- err_o  out  1  sticky; set on retry exhaustion, cleared by the next accepted start_i
- mismatch_o  out  1  sticky; set on any verify compare failure, cleared like err_o
- err_idx_o  out  IDX_W  index of the failing entry, valid while err_o=1

Behaviour:
- Reset values: all outputs 0, index 0, retry counter 0, FSM in IDLE.
- Reset mid-walk aborts at the next edge with no STOP issued. The byte controller shares rst_i.
- Command handshake:
  - Command bits and i2c_din_o are registered and held stable from the issue cycle through the cycle in which i2c_cmd_ack_i=1.
  - They are all 0 on the following cycle.
  - Exactly one command is outstanding at a time.
- Write sequence per entry:
  - START+WRITE {SLAVE_ADDR,0}.
  - ADDR_BYTES x WRITE address bytes.
  - WRITE data combined with STOP.
- Verify sequence (verify_i latched = 1), run after the write sequence:
  - START+WRITE {SLAVE_ADDR,0}.
  - Address bytes.
  - START+WRITE {SLAVE_ADDR,1}.
  - READ with ack_in=1, combined with STOP.
  - Compare i2c_dout_i to data[7:0] in the cmd_ack cycle.
- NACK handling: i2c_ack_out_i is sampled on every WRITE cmd_ack. On 1, the FSM issues a standalone STOP, waits for its cmd_ack, and treats the attempt as failed.
- Compare failure sets mismatch_o and counts as a failed attempt.
- A failed attempt restarts the entry from its write sequence. After MAX_RETRY+1 failed attempts:
  - err_o=1, err_idx_o=index.
  - Walk aborts to DONE.
- The retry counter clears on each new entry.
- States:
  - IDLE -> FETCH on start_i.
  - FETCH (drive rom_addr_o) -> LATCH (capture rom_data_i) -> ISSUE.
  - ISSUE -> WAIT.
  - WAIT on cmd_ack -> ISSUE for the next byte, RECOVER on NACK, or PAUSE at the last byte of the sequence.
  - RECOVER -> WAIT_STOP -> ISSUE (retry) or DONE (exhausted).
  - PAUSE counts PAUSE_CYCLES -> FETCH for the next index, or DONE after index NUM_ENTRIES-1.
  - DONE: done_o=1 for one cycle -> IDLE.
- busy_o=1 in every state except IDLE. It drops in the same cycle done_o pulses.
- start_i and verify_i are ignored outside IDLE.
- Index never wraps within a walk and resets to 0 on each accepted start.

Test Plan:
- ADDR_BYTES=2, NUM_ENTRIES=2, table {0x0B24_C0, 0x0B25_00}, verify_i=0, slave model ACKs all -> bytes E8,0B,24,C0+STOP then E8,0B,25,00+STOP; done_o pulses once; err_o=0.
- Same table, verify_i=1, slave echoes written data -> entry 0 shows E8,0B,24 then repeated START E9, READ C0 NACK+STOP; mismatch_o=0, err_o=0.
- Slave NACKs the address byte of entry 1 twice, then ACKs; MAX_RETRY=3 -> two standalone STOPs, third attempt succeeds, err_o=0.
- Slave NACKs entry 1 always -> exactly 4 attempts, err_o=1, err_idx_o=1, done_o pulse, busy_o=0.
- verify_i=1, slave returns 0xFF for entry 0 -> mismatch_o=1, entry retried; persistent -> err_idx_o=0.
- Assert rst_i mid-PAUSE, then start_i -> all outputs 0 after the reset edge; new walk begins at index 0; start_i pulsed during a busy walk has no effect.

Source files
------------

// File: rtl/si5340_config_sequencer.sv
// si5340_config_sequencer: walks a register table into an SI5340 through a byte-level I2C controller
module si5340_config_sequencer #(
  parameter logic [6:0] SLAVE_ADDR = 7'h74,
  parameter int ADDR_BYTES = 2,
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
  parameter int MEM_W = 8 * (ADDR_BYTES + 1),
  parameter int PAUSE_CYCLES = 1000,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             verify_i,
  output logic [IDX_W-1:0] rom_addr_o,
  input  logic [MEM_W-1:0] rom_data_i,
  output logic             i2c_start_o,
  output logic             i2c_stop_o,
  output logic             i2c_read_o,
  output logic             i2c_write_o,
  output logic             i2c_ack_in_o,
  output logic [7:0]       i2c_din_o,
  input  logic             i2c_cmd_ack_i,
  input  logic             i2c_ack_out_i,
  input  logic [7:0]       i2c_dout_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             mismatch_o,
  output logic [IDX_W-1:0] err_idx_o
);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int PW = (PAUSE_CYCLES > 0) ? $clog2(PAUSE_CYCLES + 1) : 1;
  localparam logic [3:0] WR_LAST = 4'(ADDR_BYTES + 1);
  localparam logic [3:0] VF_BASE = 4'(ADDR_BYTES + 2);
  localparam logic [3:0] VF_LAST = 4'(2 * ADDR_BYTES + 4);
  typedef enum logic [3:0] {IDLE, FETCH, LATCH, ISSUE, WAIT, RECOVER, WAIT_STOP, PAUSE, DONE} state_t;
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [MEM_W-1:0] r_entry;
  logic [3:0]       r_step;
  logic [RW-1:0]    r_retry;
  logic [PW-1:0]    r_pause;
  logic             r_verify;
  logic             w_vf, w_first, w_tail, w_rd, w_start, w_stop, w_last, w_exhausted;
  logic [3:0]       w_s;
  logic [7:0]       w_abyte, w_din;
  assign rom_addr_o = r_idx;
  // Step decode: steps 0..WR_LAST form the write sequence, VF_BASE..VF_LAST the read-back sequence
  always_comb begin
    w_vf = r_step >= VF_BASE;
    w_s = w_vf ? r_step - VF_BASE : r_step;
    w_abyte = 8'(r_entry >> (8 * (ADDR_BYTES + 1 - int'(w_s))));
    w_first = w_s == 4'd0;
    w_tail = w_s == WR_LAST;
    w_rd = w_vf && w_s == WR_LAST + 4'd1;
    w_start = w_first || (w_vf && w_tail);
    w_stop = w_rd || (!w_vf && w_tail);
    w_din = w_first ? {SLAVE_ADDR, 1'b0} : w_tail ? (w_vf ? {SLAVE_ADDR, 1'b1} : r_entry[7:0]) : w_rd ? 8'h00 : w_abyte;
    w_last = r_step == (r_verify ? VF_LAST : WR_LAST);
    w_exhausted = r_retry == RW'(MAX_RETRY);
  end
  // Table-walk FSM with registered command and status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_entry <= '0;
      r_step <= '0;
      r_retry <= '0;
      r_pause <= '0;
      r_verify <= 1'b0;
      i2c_start_o <= 1'b0;
      i2c_stop_o <= 1'b0;
      i2c_read_o <= 1'b0;
      i2c_write_o <= 1'b0;
      i2c_ack_in_o <= 1'b0;
      i2c_din_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      mismatch_o <= 1'b0;
      err_idx_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        IDLE: if (start_i) begin
          r_state <= FETCH;
          r_idx <= '0;
          r_verify <= verify_i;
          busy_o <= 1'b1;
          err_o <= 1'b0;
          mismatch_o <= 1'b0;
          err_idx_o <= '0;
        end
        FETCH: begin
          r_retry <= '0;
          r_state <= LATCH;
        end
        LATCH: begin
          r_entry <= rom_data_i;
          r_step <= '0;
          r_state <= ISSUE;
        end
        ISSUE: begin
          i2c_start_o <= w_start;
          i2c_stop_o <= w_stop;
          i2c_read_o <= w_rd;
          i2c_write_o <= !w_rd;
          i2c_ack_in_o <= w_rd;
          i2c_din_o <= w_din;
          r_state <= WAIT;
        end
        WAIT: if (i2c_cmd_ack_i) begin
          i2c_start_o <= 1'b0;
          i2c_stop_o <= 1'b0;
          i2c_read_o <= 1'b0;
          i2c_write_o <= 1'b0;
          i2c_ack_in_o <= 1'b0;
          i2c_din_o <= '0;
          if (i2c_write_o && i2c_ack_out_i) r_state <= RECOVER;
          else if (i2c_read_o && i2c_dout_i != r_entry[7:0]) begin
            mismatch_o <= 1'b1;
            if (w_exhausted) begin
              err_o <= 1'b1;
              err_idx_o <= r_idx;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              r_state <= DONE;
            end else begin
              r_retry <= r_retry + 1'b1;
              r_step <= '0;
              r_state <= ISSUE;
            end
          end else if (w_last) begin
            r_pause <= '0;
            r_state <= PAUSE;
          end else begin
            r_step <= r_step + 4'd1;
            r_state <= ISSUE;
          end
        end
        RECOVER: begin
          i2c_stop_o <= 1'b1;
          r_state <= WAIT_STOP;
        end
        WAIT_STOP: if (i2c_cmd_ack_i) begin
          i2c_stop_o <= 1'b0;
          if (w_exhausted) begin
            err_o <= 1'b1;
            err_idx_o <= r_idx;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            r_state <= DONE;
          end else begin
            r_retry <= r_retry + 1'b1;
            r_step <= '0;
            r_state <= ISSUE;
          end
        end
        PAUSE: if (int'(r_pause) + 1 >= PAUSE_CYCLES) begin
          if (r_idx == IDX_W'(NUM_ENTRIES - 1)) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
            r_state <= FETCH;
          end
        end else r_pause <= r_pause + 1'b1;
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_si5340_config_sequencer.sv
// tb_si5340_config_sequencer: scoreboarded random and directed table walks against a byte-controller model
module tb_si5340_config_sequencer;
  localparam int AB = 2, NE = 2, PC = 4, MR = 3, IW = 1, MW = 24;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, verify = 1'b0;
  logic [IW-1:0] rom_addr, err_idx;
  logic [MW-1:0] rom_data = '0;
  logic i2c_start, i2c_stop, i2c_read, i2c_write, i2c_ack_in;
  logic [7:0] i2c_din, i2c_dout;
  logic i2c_cmd_ack, i2c_ack_out;
  logic busy, done, err, mm;
  logic [12:0] cmd_bus;
  typedef struct {logic s, p, r, w; logic [7:0] din; logic nack; logic [7:0] rd;} cmd_t;
  typedef struct {logic err, mm; int idx;} st_t;
  cmd_t exp_q[$], seq[$];
  st_t st_q[$];
  logic [MW-1:0] rom [NE];
  int fails [NE], pos [NE];
  logic [7:0] bad [NE];
  int n_vec = 0, n_err = 0, dones = 0;
  always #5 clk = ~clk;
  assign cmd_bus = {i2c_start, i2c_stop, i2c_read, i2c_write, i2c_ack_in, i2c_din};
  si5340_config_sequencer #(.SLAVE_ADDR(7'h74), .ADDR_BYTES(AB), .NUM_ENTRIES(NE), .PAUSE_CYCLES(PC), .MAX_RETRY(MR)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .verify_i(verify),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .i2c_start_o(i2c_start), .i2c_stop_o(i2c_stop), .i2c_read_o(i2c_read), .i2c_write_o(i2c_write),
    .i2c_ack_in_o(i2c_ack_in), .i2c_din_o(i2c_din),
    .i2c_cmd_ack_i(i2c_cmd_ack), .i2c_ack_out_i(i2c_ack_out), .i2c_dout_i(i2c_dout),
    .busy_o(busy), .done_o(done), .err_o(err), .mismatch_o(mm), .err_idx_o(err_idx)
  );
  always @(posedge clk) rom_data <= rom[rom_addr];
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  // Full successful command list for one entry, straight from the bus protocol
  function automatic void build_seq(logic [MW-1:0] ent, bit v);
    cmd_t c;
    seq.delete();
    for (int ph = 0; ph < (v ? 2 : 1); ph++) begin
      c = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hE8, 1'b0, 8'h00};
      seq.push_back(c);
      for (int b = AB - 1; b >= 0; b--) begin
        c = '{1'b0, 1'b0, 1'b0, 1'b1, ent[8+8*b +: 8], 1'b0, 8'h00};
        seq.push_back(c);
      end
      if (ph == 0) c = '{1'b0, 1'b1, 1'b0, 1'b1, ent[7:0], 1'b0, 8'h00};
      else c = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hE9, 1'b0, 8'h00};
      seq.push_back(c);
    end
    if (v) begin
      c = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, ent[7:0]};
      seq.push_back(c);
    end
  endfunction
  // Expected transcript and final status for a whole walk under the fail plan
  function automatic void model(bit v);
    st_t st;
    cmd_t c;
    st = '{1'b0, 1'b0, 0};
    for (int e = 0; e < NE; e++) begin
      build_seq(rom[e], v);
      for (int k = 0; k < ((fails[e] > MR) ? MR + 1 : fails[e]); k++) begin
        if (pos[e] < 0) begin
          st.mm = 1'b1;
          foreach (seq[i]) begin
            c = seq[i];
            if (c.r) c.rd = bad[e];
            exp_q.push_back(c);
          end
        end else begin
          for (int i = 0; i <= pos[e]; i++) begin
            c = seq[i];
            c.nack = (i == pos[e]);
            exp_q.push_back(c);
          end
          c = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
          exp_q.push_back(c);
        end
      end
      if (fails[e] > MR) begin
        st.err = 1'b1;
        st.idx = e;
        st_q.push_back(st);
        return;
      end
      foreach (seq[i]) exp_q.push_back(seq[i]);
    end
    st_q.push_back(st);
  endfunction
  // Byte-controller model: checks each command against the scoreboard and answers as scripted
  initial begin : responder
    cmd_t e;
    logic [12:0] hold;
    bit moved;
    int d;
    i2c_cmd_ack = 1'b0;
    i2c_ack_out = 1'b0;
    i2c_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && (i2c_start || i2c_stop || i2c_read || i2c_write)) begin
        e = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        if (exp_q.size() == 0) chk("unexpected_cmd", cmd_bus, 0);
        else begin
          e = exp_q.pop_front();
          chk("cmd_bits", {i2c_start, i2c_stop, i2c_read, i2c_write}, {e.s, e.p, e.r, e.w});
          if (e.w) chk("cmd_din", i2c_din, e.din);
          if (e.r) chk("read_ack_in", i2c_ack_in, 1);
        end
        hold = cmd_bus;
        moved = 1'b0;
        d = $urandom_range(0, 3);
        repeat (d) begin
          @(negedge clk);
          if (cmd_bus !== hold) moved = 1'b1;
        end
        i2c_cmd_ack = 1'b1;
        i2c_ack_out = e.nack;
        i2c_dout = e.r ? e.rd : 8'($urandom);
        @(negedge clk);
        i2c_cmd_ack = 1'b0;
        i2c_ack_out = 1'b0;
        chk("cmd_hold", moved, 0);
        chk("cmd_clear", cmd_bus, 0);
      end
    end
  end
  // Completion monitor: pops expected walk status on each done pulse
  always @(negedge clk) begin : done_mon
    st_t s;
    if (!rst && done) begin
      dones++;
      chk("done_busy", busy, 0);
      if (st_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        s = st_q.pop_front();
        chk("err", err, s.err);
        chk("mismatch", mm, s.mm);
        if (s.err) chk("err_idx", err_idx, s.idx);
        chk("pending_cmds", exp_q.size(), 0);
      end
    end
  end
  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask
  task automatic run_walk(bit v, bit poke);
    int d0;
    model(v);
    d0 = dones;
    @(negedge clk);
    start = 1'b1;
    verify = v;
    @(negedge clk);
    start = 1'b0;
    verify = 1'($urandom);
    chk("busy_after_start", busy, 1);
    if (poke) begin
      repeat (8) @(negedge clk);
      start = 1'b1;
      verify = !v;
      @(negedge clk);
      start = 1'b0;
    end
    for (int t = 0; t < 20000 && dones == d0; t++) @(negedge clk);
    if (dones == d0) begin
      chk("walk_timeout", 0, 1);
      finish_run();
    end
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("busy_idle", busy, 0);
  endtask
  task automatic plan(int f0, int p0, int f1, int p1);
    fails[0] = f0;
    pos[0] = p0;
    fails[1] = f1;
    pos[1] = p1;
  endtask
  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin : stim
    bit v;
    int r;
    rom[0] = 24'h0B24C0;
    rom[1] = 24'h0B2500;
    bad[0] = 8'hFF;
    bad[1] = 8'hFF;
    repeat (3) @(negedge clk);
    chk("reset_status", {busy, done, err, mm, err_idx, rom_addr}, 0);
    chk("reset_cmd", cmd_bus, 0);
    rst = 1'b0;
    plan(0, 0, 0, 0);
    run_walk(1'b0, 1'b0);
    run_walk(1'b1, 1'b0);
    plan(0, 0, 2, 1);
    run_walk(1'b0, 1'b0);
    plan(0, 0, 99, 1);
    run_walk(1'b0, 1'b0);
    plan(99, -1, 0, 0);
    run_walk(1'b1, 1'b0);
    plan(0, 0, 0, 0);
    foreach (rom[e]) rom[e] = 24'($urandom);
    model(1'b0);
    @(negedge clk);
    start = 1'b1;
    verify = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 5000 && !(exp_q.size() == AB + 2 && cmd_bus == 0); t++) @(negedge clk);
    chk("reached_pause", exp_q.size(), AB + 2);
    rst = 1'b1;
    @(negedge clk);
    chk("midwalk_reset_status", {busy, done, err, mm, err_idx, rom_addr}, 0);
    chk("midwalk_reset_cmd", cmd_bus, 0);
    rst = 1'b0;
    exp_q.delete();
    st_q.delete();
    run_walk(1'b0, 1'b1);
    for (int n = 0; n < 20; n++) begin
      v = 1'($urandom_range(0, 1));
      for (int e = 0; e < NE; e++) begin
        rom[e] = 24'($urandom);
        bad[e] = rom[e][7:0] ^ 8'($urandom_range(1, 255));
        r = $urandom_range(0, 9);
        fails[e] = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, MR) : MR + 1;
        pos[e] = (v && $urandom_range(0, 1) == 1) ? -1 : $urandom_range(0, v ? 2 * AB + 3 : AB + 1);
      end
      run_walk(v, 1'b1);
    end
    finish_run();
  end
endmodule
